// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes, RV32 opcode constants and arithmetic decode helper
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_SLL   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SRA   = 4'b0110,
    ALU_SRL   = 4'b0111,
    ALU_SLTU  = 4'b1000,
    ALU_XOR   = 4'b1001,
    ALU_PASSB = 4'b1111
  } alu_ctrl_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Shared by register and immediate arithmetic; funct7b5 selects SUB and SRA.
  function automatic alu_ctrl_e arith_ctrl(input logic [2:0] funct3, input logic funct7b5);
    alu_ctrl_e ctrl;
    case (funct3)
      3'b000:  ctrl = funct7b5 ? ALU_SUB : ALU_ADD;
      3'b001:  ctrl = ALU_SLL;
      3'b010:  ctrl = ALU_SLT;
      3'b011:  ctrl = ALU_SLTU;
      3'b100:  ctrl = ALU_XOR;
      3'b101:  ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  ctrl = ALU_OR;
      default: ctrl = ALU_AND;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_ctrl_enc.sv
// rtl/alu_ctrl_enc.sv - combinational decode of opcode/funct fields into ALU operands and control
module alu_ctrl_enc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [3:0]       alu_ctrl,
  output logic             illegal
);

  always_comb begin
    a        = '0;
    b        = '0;
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        a        = rs1_val;
        b        = rs2_val;
        alu_ctrl = arith_ctrl(funct3, funct7b5);
      end
      OP_I: begin
        a        = rs1_val;
        b        = imm;
        alu_ctrl = (funct3 == 3'b000) ? ALU_ADD : arith_ctrl(funct3, funct7b5);
      end
      OP_LUI: begin
        b        = imm;
        alu_ctrl = ALU_PASSB;
      end
      OP_AUIPC, OP_JAL: begin
        a = pc;
        b = imm;
      end
      OP_LOAD, OP_STORE, OP_JALR: begin
        a = rs1_val;
        b = imm;
      end
      OP_BRANCH: begin
        // Compare-type branches pair on funct3[2:1]; the 01x pair has no encoding.
        case (funct3[2:1])
          2'b00: begin a = rs1_val; b = rs2_val; alu_ctrl = ALU_SUB;  end
          2'b10: begin a = rs1_val; b = rs2_val; alu_ctrl = ALU_SLT;  end
          2'b11: begin a = rs1_val; b = rs2_val; alu_ctrl = ALU_SLTU; end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU issue stage: decode plus 2-entry output FIFO; ALU_ISSUE_STATS_EN adds pop counters
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [WIDTH-1:0] imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [3:0]       alu_ctrl,
`ifdef ALU_ISSUE_STATS_EN
  output logic [31:0]      issue_cnt,
  output logic [15:0]      illegal_cnt,
`endif
  output logic             illegal
);

  logic [WIDTH-1:0] enc_a, enc_b;
  logic [3:0]       enc_ctrl;
  logic             enc_illegal;

  alu_ctrl_enc #(.WIDTH(WIDTH)) u_enc (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .pc       (pc),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .imm      (imm),
    .a        (enc_a),
    .b        (enc_b),
    .alu_ctrl (enc_ctrl),
    .illegal  (enc_illegal)
  );

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_a_q [2], mem_a_d [2];
  logic [WIDTH-1:0] mem_b_q [2], mem_b_d [2];
  logic [3:0]       mem_ctrl_q [2], mem_ctrl_d [2];
  logic             mem_ill_q [2], mem_ill_d [2];
  logic             push, pop;

  assign in_ready  = ~count_q[1];
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_a_d    = mem_a_q;
    mem_b_d    = mem_b_q;
    mem_ctrl_d = mem_ctrl_q;
    mem_ill_d  = mem_ill_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        mem_a_d[wr_ptr_q]    = enc_a;
        mem_b_d[wr_ptr_q]    = enc_b;
        mem_ctrl_d[wr_ptr_q] = enc_ctrl;
        mem_ill_d[wr_ptr_q]  = enc_illegal;
        wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      mem_a_q    <= '{default: '0};
      mem_b_q    <= '{default: '0};
      mem_ctrl_q <= '{default: '0};
      mem_ill_q  <= '{default: 1'b0};
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_a_q    <= mem_a_d;
      mem_b_q    <= mem_b_d;
      mem_ctrl_q <= mem_ctrl_d;
      mem_ill_q  <= mem_ill_d;
    end
  end

  // Empty FIFO presents all-zero outputs so stale entries never leak after flush.
  assign a        = out_valid ? mem_a_q[rd_ptr_q]    : '0;
  assign b        = out_valid ? mem_b_q[rd_ptr_q]    : '0;
  assign alu_ctrl = out_valid ? mem_ctrl_q[rd_ptr_q] : 4'b0000;
  assign illegal  = out_valid ? mem_ill_q[rd_ptr_q]  : 1'b0;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] illegal_cnt_q, illegal_cnt_d;

  always_comb begin
    issue_cnt_d   = issue_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (pop) begin
      issue_cnt_d = issue_cnt_q + 32'd1;
      if (illegal) illegal_cnt_d = illegal_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      issue_cnt_q   <= issue_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign issue_cnt   = issue_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed vector bench for alu_issue; covers ALU_ISSUE_STATS_EN when defined
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, funct7b5, flush, out_valid, out_ready, illegal;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] pc, rs1_val, rs2_val, imm, a, b;
  logic [3:0]  alu_ctrl;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issue_cnt;
  logic [15:0] illegal_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .pc        (pc),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .imm       (imm),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .alu_ctrl  (alu_ctrl),
`ifdef ALU_ISSUE_STATS_EN
    .issue_cnt   (issue_cnt),
    .illegal_cnt (illegal_cnt),
`endif
    .illegal   (illegal)
  );

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [3:0]  ectrl;
    logic        eill;
    logic        chk_a;
  } vec_t;

  localparam logic [31:0] PC  = 32'h0000_1000;
  localparam logic [31:0] RS1 = 32'd10;
  localparam logic [31:0] RS2 = 32'd3;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic [31:0] r1, input logic [31:0] im);
    in_valid = v;
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
    pc       = PC;
    rs1_val  = r1;
    rs2_val  = RS2;
    imm      = im;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".a"}, a, 32'd0);
    chk({tag, ".b"}, b, 32'd0);
    chk({tag, ".alu_ctrl"}, {28'd0, alu_ctrl}, 32'd0);
    chk({tag, ".illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  function automatic vec_t mk(string n, logic [6:0] op, logic [2:0] f3, logic f7, logic [31:0] im,
                              logic [31:0] ea, logic [31:0] eb, logic [3:0] ec, logic ei, logic ca);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.imm = im;
    v.ea = ea; v.eb = eb; v.ectrl = ec; v.eill = ei; v.chk_a = ca;
    return v;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back(mk("r_sub",   7'b0110011, 3'b000, 1'b1, 32'h0,        RS1, RS2,          4'b0001, 1'b0, 1'b1));
    vecs.push_back(mk("r_add",   7'b0110011, 3'b000, 1'b0, 32'h0,        RS1, RS2,          4'b0000, 1'b0, 1'b1));
    vecs.push_back(mk("r_sll",   7'b0110011, 3'b001, 1'b0, 32'h0,        RS1, RS2,          4'b0100, 1'b0, 1'b1));
    vecs.push_back(mk("r_slt",   7'b0110011, 3'b010, 1'b0, 32'h0,        RS1, RS2,          4'b0101, 1'b0, 1'b1));
    vecs.push_back(mk("r_sltu",  7'b0110011, 3'b011, 1'b0, 32'h0,        RS1, RS2,          4'b1000, 1'b0, 1'b1));
    vecs.push_back(mk("r_xor",   7'b0110011, 3'b100, 1'b0, 32'h0,        RS1, RS2,          4'b1001, 1'b0, 1'b1));
    vecs.push_back(mk("r_sra",   7'b0110011, 3'b101, 1'b1, 32'h0,        RS1, RS2,          4'b0110, 1'b0, 1'b1));
    vecs.push_back(mk("r_srl",   7'b0110011, 3'b101, 1'b0, 32'h0,        RS1, RS2,          4'b0111, 1'b0, 1'b1));
    vecs.push_back(mk("r_or",    7'b0110011, 3'b110, 1'b0, 32'h0,        RS1, RS2,          4'b0011, 1'b0, 1'b1));
    vecs.push_back(mk("r_and",   7'b0110011, 3'b111, 1'b0, 32'h0,        RS1, RS2,          4'b0010, 1'b0, 1'b1));
    vecs.push_back(mk("i_addi7", 7'b0010011, 3'b000, 1'b1, 32'hFFFFFFF0, RS1, 32'hFFFFFFF0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(mk("i_srai",  7'b0010011, 3'b101, 1'b1, 32'h00000004, RS1, 32'h00000004, 4'b0110, 1'b0, 1'b1));
    vecs.push_back(mk("i_andi",  7'b0010011, 3'b111, 1'b0, 32'h000000FF, RS1, 32'h000000FF, 4'b0010, 1'b0, 1'b1));
    vecs.push_back(mk("lui",     7'b0110111, 3'b000, 1'b0, 32'h12345000, 32'h0, 32'h12345000, 4'b1111, 1'b0, 1'b0));
    vecs.push_back(mk("auipc",   7'b0010111, 3'b000, 1'b0, 32'h00002000, PC,  32'h00002000, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(mk("load",    7'b0000011, 3'b010, 1'b0, 32'h00000010, RS1, 32'h00000010, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(mk("store",   7'b0100011, 3'b010, 1'b0, 32'hFFFFFFFC, RS1, 32'hFFFFFFFC, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(mk("jal",     7'b1101111, 3'b000, 1'b0, 32'h00000400, PC,  32'h00000400, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(mk("jalr",    7'b1100111, 3'b000, 1'b0, 32'h00000008, RS1, 32'h00000008, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(mk("beq",     7'b1100011, 3'b000, 1'b0, 32'h00000020, RS1, RS2,          4'b0001, 1'b0, 1'b1));
    vecs.push_back(mk("bge",     7'b1100011, 3'b101, 1'b0, 32'h00000020, RS1, RS2,          4'b0101, 1'b0, 1'b1));
    vecs.push_back(mk("bltu",    7'b1100011, 3'b110, 1'b0, 32'h00000020, RS1, RS2,          4'b1000, 1'b0, 1'b1));
    vecs.push_back(mk("br_f3_2", 7'b1100011, 3'b010, 1'b0, 32'h00000020, 32'h0, 32'h0,      4'b0000, 1'b1, 1'b1));
    vecs.push_back(mk("bad_op",  7'b1111111, 3'b000, 1'b0, 32'h00000020, 32'h0, 32'h0,      4'b0000, 1'b1, 1'b1));

    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 7'd0, 3'd0, 1'b0, RS1, 32'd0);
    tick();
    tick();
    chk_reset_state("reset");
    reset = 1'b0;

    // Decode table: one op at a time, latency 1, popped the following edge.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7, RS1, vecs[i].imm);
      tick();
      chk({vecs[i].name, ".out_valid"}, {31'd0, out_valid}, 32'd1);
      if (vecs[i].chk_a) chk({vecs[i].name, ".a"}, a, vecs[i].ea);
      chk({vecs[i].name, ".b"}, b, vecs[i].eb);
      chk({vecs[i].name, ".alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, vecs[i].ectrl});
      chk({vecs[i].name, ".illegal"}, {31'd0, illegal}, {31'd0, vecs[i].eill});
      in_valid = 1'b0;
      tick();
      chk({vecs[i].name, ".drained"}, {31'd0, out_valid}, 32'd0);
    end

    // Back-pressure: two accepted, third refused, delivered in order.
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd1, 32'd0);
    tick();
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd2, 32'd0);
    tick();
    chk("bp.in_ready_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd3, 32'd0);
    tick();
    chk("bp.in_ready_held", {31'd0, in_ready}, 32'd0);
    chk("bp.head_stable", a, 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp.first", a, 32'd1);
    tick();
    chk("bp.second_valid", {31'd0, out_valid}, 32'd1);
    chk("bp.second", a, 32'd2);
    tick();
    chk("bp.empty", {31'd0, out_valid}, 32'd0);

    // Simultaneous push and pop at count 1.
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd5, 32'd0);
    tick();
    out_ready = 1'b1;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd6, 32'd0);
    tick();
    chk("pp.out_valid", {31'd0, out_valid}, 32'd1);
    chk("pp.in_ready", {31'd0, in_ready}, 32'd1);
    chk("pp.head", a, 32'd6);
    in_valid = 1'b0;
    tick();
    chk("pp.empty", {31'd0, out_valid}, 32'd0);

    // Flush on a full FIFO drops contents and the same-cycle push.
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd7, 32'd0);
    tick();
    tick();
    chk("fl.full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("fl.no_push", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream discards the in-flight op.
    drive(1'b1, 7'b0110111, 3'b000, 1'b0, 32'd0, 32'hABCD0000);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk_reset_state("mid_reset");

`ifdef ALU_ISSUE_STATS_EN
    chk("st.issue_reset", issue_cnt, 32'd0);
    chk("st.illegal_reset", {16'd0, illegal_cnt}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 1 || k == 3) drive(1'b1, 7'b1111111, 3'b000, 1'b0, 32'd0, 32'd0);
      else                  drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd9, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("st.issue5", issue_cnt, 32'd5);
    chk("st.illegal2", {16'd0, illegal_cnt}, 32'd2);
    out_ready = 1'b0;
    drive(1'b1, 7'b1111111, 3'b000, 1'b0, 32'd0, 32'd0);
    tick();
    flush = 1'b1; in_valid = 1'b0;
    tick();
    flush = 1'b0;
    chk("st.issue_flush", issue_cnt, 32'd5);
    chk("st.illegal_flush", {16'd0, illegal_cnt}, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
